// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and LFSR step function for the shared 16-bit Fibonacci LFSR.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned TAP0   = 0;
  localparam int unsigned TAP1   = 2;
  localparam int unsigned TAP2   = 3;
  localparam int unsigned TAP3   = 5;

  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    GRANT   = 2'd2
  } state_e;

  // One right-shift step; feedback enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[TAP0] ^ cur[TAP1] ^ cur[TAP2] ^ cur[TAP3], cur[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit Fibonacci LFSR register with load (priority) and single-step enable.
module lfsr16_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_en,
  input  logic              load_en,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      lfsr_d = load_val;
    end else if (step_en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Round-robin sequencer sharing one LFSR among N requesters via req/ack.
// Optional LFSR_ZERO_GUARD_EN: a zero seed_load loads DEFAULT_SEED instead.
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned       N            = 4,
  parameter int unsigned       STEPS        = 4,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [N-1:0]      req,
  output logic [N-1:0]      ack,
  output logic [LFSR_W-1:0] rnd_out,
  output logic              rnd_valid,
  output logic              busy
);

  localparam int unsigned RR_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_e            state_q, state_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic [RR_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      ack_q, ack_d;
  logic [LFSR_W-1:0] rnd_q, rnd_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [LFSR_W-1:0] lfsr_cur;
  logic [LFSR_W-1:0] load_val_c;
  logic              step_en_c;
  logic              any_c;
  logic [RR_W-1:0]   pick_c;
  logic [RR_W-1:0]   rr_next_c;

`ifdef LFSR_ZERO_GUARD_EN
  assign load_val_c = (seed == '0) ? DEFAULT_SEED : seed;
`else
  assign load_val_c = seed;
`endif

  lfsr16_core #(
    .RESET_VAL (DEFAULT_SEED)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .step_en  (step_en_c),
    .load_en  (seed_load),
    .load_val (load_val_c),
    .lfsr     (lfsr_cur)
  );

  // Round-robin pick: scan from rr downward in priority so the closest-to-rr request wins.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    any_c  = 1'b0;
    pick_c = rr_q;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (32'(rr_q) + 32'(i)) % N;
      if (req[RR_W'(idx)]) begin
        any_c  = 1'b1;
        pick_c = RR_W'(idx);
      end
    end
  end

  assign rr_next_c = (win_q == RR_W'(N - 1)) ? '0 : win_q + RR_W'(1);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    rnd_d     = rnd_q;
    valid_d   = 1'b0;
    step_en_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          win_d   = pick_c;
          cnt_d   = '0;
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        step_en_c = 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = GRANT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GRANT: begin
        if (req[win_q]) begin
          ack_d[win_q] = 1'b1;
          valid_d      = 1'b1;
          rnd_d        = lfsr_cur;
          rr_d         = rr_next_c;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Seed load aborts any transaction in flight and suppresses a pending grant.
    if (seed_load) begin
      state_d   = IDLE;
      ack_d     = '0;
      valid_d   = 1'b0;
      rnd_d     = rnd_q;
      rr_d      = rr_q;
      step_en_c = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign rnd_out   = rnd_q;
  assign rnd_valid = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Directed and randomized bench for lfsr_share_ctrl against a behavioural LFSR/round-robin model.
module tb_lfsr_share_ctrl;

  localparam int N     = 4;
  localparam int STEPS = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          seed_load;
  logic [15:0]   seed;
  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic [15:0]   rnd_out;
  logic          rnd_valid;
  logic          busy;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   m_lfsr;
  logic [15:0]   m_last;
  int            m_rr;

  always #5 clk = ~clk;

  lfsr_share_ctrl #(
    .N            (N),
    .STEPS        (STEPS),
    .DEFAULT_SEED (16'hACE1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .ack       (ack),
    .rnd_out   (rnd_out),
    .rnd_valid (rnd_valid),
    .busy      (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
    return r;
  endfunction

  function automatic int m_pick(input logic [N-1:0] m, input int rr);
    for (int k = 0; k < N; k++) if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [15:0] m_seed(input logic [15:0] s);
`ifdef LFSR_ZERO_GUARD_EN
    return (s == 16'h0000) ? 16'hACE1 : s;
`else
    return s;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (ack == '0 && cyc < 60);
  endtask

  // Called with FSM idle and req just driven; arbitration happens at the next edge.
  task automatic expect_delivery(input string tag, input logic [N-1:0] arb_mask);
    int cyc;
    int w;
    w      = m_pick(arb_mask, m_rr);
    m_lfsr = m_adv(m_lfsr, STEPS);
    wait_ack(cyc);
    chk({tag, "_lat"},   32'(cyc), 32'(STEPS + 2));
    chk({tag, "_ack"},   32'(ack), 32'(1) << w);
    chk({tag, "_valid"}, 32'(rnd_valid), 32'(1));
    chk({tag, "_rnd"},   32'(rnd_out), 32'(m_lfsr));
    m_last = m_lfsr;
    m_rr   = (w + 1) % N;
  endtask

  task automatic post_check(input string tag);
    tick();
    chk({tag, "_ack0"}, 32'(ack), 32'(0));
    chk({tag, "_val0"}, 32'(rnd_valid), 32'(0));
    chk({tag, "_hold"}, 32'(rnd_out), 32'(m_last));
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    m_lfsr    = m_seed(s);
  endtask

  initial begin
    int          order [5] = '{0, 1, 2, 3, 0};
    logic        saw_ack;
    logic [N-1:0] mask;

    reset     = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0000;
    req       = '0;
    m_lfsr    = 16'hACE1;
    m_last    = 16'h0000;
    m_rr      = 0;
    tick();
    tick();
    chk("rst_ack",   32'(ack), 32'(0));
    chk("rst_rnd",   32'(rnd_out), 32'(0));
    chk("rst_valid", 32'(rnd_valid), 32'(0));
    chk("rst_busy",  32'(busy), 32'(0));
    reset = 1'b1;
    tick();

    // Single requester from the default seed.
    req = 4'b0001;
    expect_delivery("single", req);
    req = '0;
    post_check("single");

    // Known seed: 0001 shifted four times gives 1000.
    load_seed(16'h0001);
    req = 4'b0100;
    expect_delivery("seed1", req);
    chk("seed1_const", 32'(rnd_out), 32'h1000);
    req = '0;
    post_check("seed1");

    // Asynchronous reset in the middle of ADVANCE.
    req = 4'b0001;
    tick();
    tick();
    chk("midrst_busy_pre", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_rnd",  32'(rnd_out), 32'(0));
    req = '0;
    tick();
    reset  = 1'b1;
    m_lfsr = 16'hACE1;
    m_last = 16'h0000;
    m_rr   = 0;
    tick();

    // All requesters held high: rotation 0,1,2,3,0.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      expect_delivery("rrall", 4'b1111);
      chk("rrall_order", 32'(ack), 32'(1) << order[k]);
    end
    req = '0;
    post_check("rrall");

    // req[1] dropped during ADVANCE: no ack, rr unchanged, LFSR keeps advancing.
    req = 4'b0010;
    tick();
    chk("drop_busy", 32'(busy), 32'(1));
    req     = '0;
    m_lfsr  = m_adv(m_lfsr, STEPS);
    saw_ack = 1'b0;
    for (int k = 0; k < STEPS + 3; k++) begin
      tick();
      if (ack != '0 || rnd_valid) saw_ack = 1'b1;
    end
    chk("drop_noack", 32'(saw_ack), 32'(0));
    chk("drop_idle",  32'(busy), 32'(0));
    chk("drop_hold",  32'(rnd_out), 32'(m_last));
    req = 4'b0011;
    expect_delivery("drop_next", 4'b0011);
    chk("drop_winner", 32'(ack), 32'h2);
    req = '0;
    post_check("drop_next");

    // seed_load during GRANT: grant suppressed, requester re-served from the new seed.
    req = 4'b0100;
    tick();
    for (int k = 0; k < STEPS; k++) tick();
    chk("sgrant_busy", 32'(busy), 32'(1));
    load_seed(16'hBEEF);
    chk("sgrant_ack0",  32'(ack), 32'(0));
    chk("sgrant_val0",  32'(rnd_valid), 32'(0));
    chk("sgrant_idle",  32'(busy), 32'(0));
    chk("sgrant_hold",  32'(rnd_out), 32'(m_last));
    expect_delivery("sgrant", 4'b0100);
    req = '0;
    post_check("sgrant");

    // Zero seed behaviour, two deliveries.
    load_seed(16'h0000);
    req = 4'b0001;
    expect_delivery("zero_a", req);
`ifndef LFSR_ZERO_GUARD_EN
    chk("zero_a_const", 32'(rnd_out), 32'h0);
`endif
    req = '0;
    post_check("zero_a");
    req = 4'b1000;
    expect_delivery("zero_b", req);
`ifndef LFSR_ZERO_GUARD_EN
    chk("zero_b_const", 32'(rnd_out), 32'h0);
`endif
    req = '0;
    post_check("zero_b");

    // Randomized masks with occasional random reseeds.
    load_seed(16'h1D2C);
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0) load_seed(16'($urandom));
      mask = N'($urandom_range(1, (1 << N) - 1));
      req  = mask;
      expect_delivery("rand", mask);
      req = '0;
      post_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
